axil_gpio_slave: RTL and testbench
==================================

// Module: axil_gpio_slave
// PURPOSE
//  AXI4-Lite responder exposing a GPIO bank to a master (PS or VIP master agent).
//  Four 32-bit registers: output data, direction, synchronised input, edge-IRQ status.
//  Drives pad-side out/output-enable, samples pad inputs, raises a level interrupt.
// PARAMETERS
//  C_S_AXI_DATA_WIDTH  32  AXI data width; only 32 supported
//  C_S_AXI_ADDR_WIDTH  4   byte address width; word index = ADDR[3:2]
//  GPIO_WIDTH          32  number of GPIO pins (1..32); unused register bits read 0
// PORTS
//  ACLK            in   1    single clock
//  ARESET          in   1    asynchronous, active-high reset
//  S_AXI_AWADDR    in   4    write address
//  S_AXI_AWPROT    in   3    ignored
//  S_AXI_AWVALID   in   1  / S_AXI_AWREADY out 1   write address handshake
//  S_AXI_WDATA     in   32   write data
//  S_AXI_WSTRB     in   4    byte lane enables
//  S_AXI_WVALID    in   1  / S_AXI_WREADY  out 1   write data handshake
//  S_AXI_BRESP     out  2    always 2'b00 (OKAY)
//  S_AXI_BVALID    out  1  / S_AXI_BREADY  in  1   write response handshake
//  S_AXI_ARADDR    in   4    read address; S_AXI_ARPROT in 3 ignored
//  S_AXI_ARVALID   in   1  / S_AXI_ARREADY out 1   read address handshake
//  S_AXI_RDATA     out  32   read data
//  S_AXI_RRESP     out  2    always 2'b00 (OKAY)
//  S_AXI_RVALID    out  1  / S_AXI_RREADY  in  1   read data handshake
//  gpio_i          in   GPIO_WIDTH  pad inputs (asynchronous)
//  gpio_o          out  GPIO_WIDTH  pad output data = OUT reg
//  gpio_oe         out  GPIO_WIDTH  pad output enable = DIR reg (1 = drive)
//  irq             out  1    |IRQ_STAT, registered
// BEHAVIOUR
//  Reset: all READY/VALID low, RDATA 0, OUT=0, DIR=0 (all inputs), IRQ_STAT=0, irq=0,
//   sync flops 0. Reset takes effect immediately; outstanding transactions are dropped.
//  Map: 0x0 OUT RW | 0x4 DIR RW | 0x8 IN RO (write ignored, OKAY) | 0xC IRQ_STAT W1C.
//  Write channel FSM: W_IDLE -> (AW and/or W captured) -> W_RESP -> W_IDLE.
//   - AWREADY/WREADY high in W_IDLE while that channel not yet captured; each channel
//     captured independently, any order, same cycle allowed.
//   - Register update in the cycle after both captured; BVALID asserts same cycle.
//   - BVALID held until BREADY; no new AW/W accepted while BVALID high.
//   - WSTRB[n] gates byte n for OUT, DIR and W1C mask of IRQ_STAT.
//  Read channel FSM: R_IDLE -> R_DATA -> R_IDLE.
//   - ARREADY high in R_IDLE; on ARVALID&&ARREADY, RDATA latched, RVALID=1 next cycle.
//   - RDATA/RVALID stable until RREADY; then ARREADY returns next cycle.
//   - Read and write channels fully independent; same-cycle read of a register being
//     written returns the pre-write value.
//  Input path: 2-flop synchroniser on gpio_i, then one history flop; IN reads sync stage.
//   Input latency gpio_i -> IN visible: 2 ACLK edges.
//  IRQ_STAT[n] set on synchronised rising edge of gpio_i[n] when DIR[n]=0.
//   Simultaneous set event and W1C on same bit: set wins (bit stays 1).
//   irq = registered OR of IRQ_STAT; asserts 1 cycle after status bit sets.
//  Bits >= GPIO_WIDTH: write-ignored, read 0, never set status.
// TESTING
//  1 Reset: assert ARESET mid-write (AW accepted, W pending) -> BVALID=0, OUT=0 after
//    release; next full write accepted normally.
//  2 Write 0xA5A5_00FF to 0x0 WSTRB=4'b0101 after OUT=0 -> gpio_o=0x00A5_00FF, BRESP=0,
//    readback 0x0 returns 0x00A5_00FF.
//  3 W presented 3 cycles before AW, BREADY held low 5 cycles -> single write, BVALID
//    stays high 5 cycles, AWREADY/WREADY low throughout.
//  4 DIR=0, gpio_i 0->0x0000_0008 -> IN reads 0x8 within 3 cycles, IRQ_STAT=0x8,
//    irq=1; write 0x8 to 0xC -> IRQ_STAT=0, irq=0 next cycle.
//  5 Same-cycle W1C of bit 3 and new rising edge on gpio_i[3] -> IRQ_STAT[3]=1, irq=1.
//  6 Back-to-back reads 0x0,0x4,0x8,0xC with RREADY low 2 cycles each -> RDATA stable
//    while RVALID high, values match model; write to 0x8 leaves IN unchanged, BRESP=0.

Source files
------------

// File: rtl/axil_gpio_slave.sv
// axil_gpio_slave: AXI4-Lite GPIO bank with OUT, DIR, IN and W1C edge-IRQ registers.
// Ports: ACLK/ARESET (async, active-high); S_AXI_* AXI4-Lite slave (AW/W/B, AR/R);
// gpio_i pad inputs (async, synchronised), gpio_o pad data (OUT), gpio_oe pad
// enable (DIR, 1 = drive), irq registered OR of the IRQ status bits.
module axil_gpio_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int GPIO_WIDTH         = 32
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic [GPIO_WIDTH-1:0]           gpio_i,
  output logic [GPIO_WIDTH-1:0]           gpio_o,
  output logic [GPIO_WIDTH-1:0]           gpio_oe,
  output logic                            irq
);
  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  w_state_t w_state_q;
  r_state_t r_state_q;
  logic awready_q, wready_q, bvalid_q, aw_got_q, w_got_q;
  logic [1:0] awidx_q;
  logic [31:0] wdata_q;
  logic [3:0] wstrb_q;
  logic arready_q, rvalid_q;
  logic [31:0] rdata_q;
  logic [GPIO_WIDTH-1:0] out_q, dir_q, stat_q, s1_q, s2_q, hist_q;
  logic irq_q;
  logic aw_hs, w_hs, aw_have, w_have, wr_en;
  logic [1:0] wr_idx;
  logic [31:0] wr_data, byte_mask, rd_val;
  logic [3:0] wr_strb;
  logic [GPIO_WIDTH-1:0] wr_mask, wr_val, rise;
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
  always_comb begin
    aw_hs     = S_AXI_AWVALID && awready_q;
    w_hs      = S_AXI_WVALID && wready_q;
    aw_have   = aw_got_q || aw_hs;
    w_have    = w_got_q || w_hs;
    // The write commits on the edge that completes the second of the two captures,
    // so the bus values are used directly when that capture is happening now.
    wr_en     = (w_state_q == W_IDLE) && aw_have && w_have;
    wr_idx    = aw_hs ? S_AXI_AWADDR[3:2] : awidx_q;
    wr_data   = w_hs ? S_AXI_WDATA : wdata_q;
    wr_strb   = w_hs ? S_AXI_WSTRB : wstrb_q;
    byte_mask = {{8{wr_strb[3]}}, {8{wr_strb[2]}}, {8{wr_strb[1]}}, {8{wr_strb[0]}}};
    wr_mask   = byte_mask[GPIO_WIDTH-1:0];
    wr_val    = wr_data[GPIO_WIDTH-1:0] & wr_mask;
    rise      = s2_q & ~hist_q & ~dir_q;
    rd_val    = (S_AXI_ARADDR[3:2] == 2'd0) ? 32'(out_q) :
                (S_AXI_ARADDR[3:2] == 2'd1) ? 32'(dir_q) :
                (S_AXI_ARADDR[3:2] == 2'd2) ? 32'(s2_q)  : 32'(stat_q);
  end
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      awidx_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else if (w_state_q == W_IDLE) begin
      if (aw_hs) awidx_q <= S_AXI_AWADDR[3:2];
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
      if (wr_en) begin
        w_state_q <= W_RESP;
        bvalid_q  <= 1'b1;
        awready_q <= 1'b0;
        wready_q  <= 1'b0;
        aw_got_q  <= 1'b0;
        w_got_q   <= 1'b0;
      end else begin
        aw_got_q  <= aw_have;
        w_got_q   <= w_have;
        awready_q <= !aw_have;
        wready_q  <= !w_have;
      end
    end else if (S_AXI_BREADY) begin
      w_state_q <= W_IDLE;
      bvalid_q  <= 1'b0;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
    end
  end
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else if (r_state_q == R_IDLE) begin
      if (S_AXI_ARVALID && arready_q) begin
        r_state_q <= R_DATA;
        arready_q <= 1'b0;
        rvalid_q  <= 1'b1;
        rdata_q   <= rd_val;
      end else begin
        arready_q <= 1'b1;
      end
    end else if (S_AXI_RREADY) begin
      r_state_q <= R_IDLE;
      rvalid_q  <= 1'b0;
      arready_q <= 1'b1;
    end
  end
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      out_q  <= '0;
      dir_q  <= '0;
      stat_q <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      hist_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (wr_en && wr_idx == 2'd0) out_q <= (out_q & ~wr_mask) | wr_val;
      if (wr_en && wr_idx == 2'd1) dir_q <= (dir_q & ~wr_mask) | wr_val;
      // Rising edges are ORed in after the W1C clear, so a coincident set wins.
      stat_q <= (stat_q & ~((wr_en && wr_idx == 2'd3) ? wr_val : '0)) | rise;
      s1_q   <= gpio_i;
      s2_q   <= s1_q;
      hist_q <= s2_q;
      irq_q  <= |stat_q;
    end
  end
  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign gpio_o        = out_q;
  assign gpio_oe       = dir_q;
  assign irq           = irq_q;
endmodule

// File: tb/tb_axil_gpio_slave.sv
// tb_axil_gpio_slave: directed self-checking bench for the AXI4-Lite GPIO slave.
module tb_axil_gpio_slave;
  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  logic [3:0] S_AXI_AWADDR = '0, S_AXI_ARADDR = '0;
  logic [2:0] S_AXI_AWPROT = '0, S_AXI_ARPROT = '0;
  logic S_AXI_AWVALID = 1'b0, S_AXI_WVALID = 1'b0, S_AXI_BREADY = 1'b0;
  logic S_AXI_ARVALID = 1'b0, S_AXI_RREADY = 1'b0;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0] S_AXI_WSTRB = '0;
  logic [31:0] gpio_i = '0;
  logic S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, irq;
  logic [1:0] S_AXI_BRESP, S_AXI_RRESP;
  logic [31:0] S_AXI_RDATA, gpio_o, gpio_oe;
  int checks = 0;
  int errors = 0;
  logic [31:0] rd;
  always #5 ACLK = ~ACLK;
  axil_gpio_slave dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe), .irq(irq)
  );
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask
  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    bit ad, wd, ah, wh;
    ad = 0;
    wd = 0;
    S_AXI_AWADDR = a;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = d;
    S_AXI_WSTRB = s;
    S_AXI_WVALID = 1'b1;
    S_AXI_BREADY = 1'b0;
    for (int n = 0; n < 20 && !(ad && wd); n++) begin
      ah = S_AXI_AWVALID && S_AXI_AWREADY;
      wh = S_AXI_WVALID && S_AXI_WREADY;
      tick();
      if (ah) begin ad = 1; S_AXI_AWVALID = 1'b0; end
      if (wh) begin wd = 1; S_AXI_WVALID = 1'b0; end
    end
    check("wr_handshakes", 32'({ad, wd}), 32'h3);
    for (int n = 0; n < 20 && !S_AXI_BVALID; n++) tick();
    check("wr_bvalid", 32'(S_AXI_BVALID), 32'h1);
    check("wr_bresp", 32'(S_AXI_BRESP), 32'h0);
    S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;
  endtask
  task automatic axi_read(input logic [3:0] a, input int stall, output logic [31:0] d);
    S_AXI_ARADDR = a;
    S_AXI_ARVALID = 1'b1;
    S_AXI_RREADY = 1'b0;
    for (int n = 0; n < 20 && !S_AXI_ARREADY; n++) tick();
    check("rd_arready", 32'(S_AXI_ARREADY), 32'h1);
    tick();
    S_AXI_ARVALID = 1'b0;
    for (int n = 0; n < 20 && !S_AXI_RVALID; n++) tick();
    check("rd_rvalid", 32'(S_AXI_RVALID), 32'h1);
    check("rd_rresp", 32'(S_AXI_RRESP), 32'h0);
    d = S_AXI_RDATA;
    for (int i = 0; i < stall; i++) begin
      tick();
      check("rd_rvalid_held", 32'(S_AXI_RVALID), 32'h1);
      check("rd_rdata_stable", S_AXI_RDATA, d);
    end
    S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_RREADY = 1'b0;
    check("rd_rvalid_clear", 32'(S_AXI_RVALID), 32'h0);
  endtask
  initial begin
    tick();
    check("rst_awready", 32'(S_AXI_AWREADY), 32'h0);
    check("rst_wready", 32'(S_AXI_WREADY), 32'h0);
    check("rst_arready", 32'(S_AXI_ARREADY), 32'h0);
    check("rst_bvalid", 32'(S_AXI_BVALID), 32'h0);
    check("rst_rvalid", 32'(S_AXI_RVALID), 32'h0);
    check("rst_rdata", S_AXI_RDATA, 32'h0);
    check("rst_gpio_o", gpio_o, 32'h0);
    check("rst_gpio_oe", gpio_oe, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    ARESET = 1'b0;
    tick();
    tick();
    axi_write(4'h0, 32'h0000_0011, 4'hF);
    check("t1_out_before_reset", gpio_o, 32'h0000_0011);
    S_AXI_AWADDR = 4'h0;
    S_AXI_AWVALID = 1'b1;
    check("t1_awready", 32'(S_AXI_AWREADY), 32'h1);
    tick();
    S_AXI_AWVALID = 1'b0;
    check("t1_aw_captured", 32'(S_AXI_AWREADY), 32'h0);
    #2 ARESET = 1'b1;
    #1;
    check("t1_mid_bvalid", 32'(S_AXI_BVALID), 32'h0);
    check("t1_mid_wready", 32'(S_AXI_WREADY), 32'h0);
    check("t1_mid_gpio_o", gpio_o, 32'h0);
    tick();
    ARESET = 1'b0;
    tick();
    tick();
    check("t1_post_bvalid", 32'(S_AXI_BVALID), 32'h0);
    check("t1_post_gpio_o", gpio_o, 32'h0);
    axi_write(4'h0, 32'h0000_0077, 4'hF);
    check("t1_next_write", gpio_o, 32'h0000_0077);
    axi_write(4'h0, 32'h0, 4'hF);
    check("t2_out_zero", gpio_o, 32'h0);
    axi_write(4'h0, 32'hA5A5_00FF, 4'b0101);
    check("t2_gpio_o", gpio_o, 32'h00A5_00FF);
    axi_read(4'h0, 0, rd);
    check("t2_readback", rd, 32'h00A5_00FF);
    S_AXI_WDATA = 32'h1234_5678;
    S_AXI_WSTRB = 4'hF;
    S_AXI_WVALID = 1'b1;
    check("t3_wready", 32'(S_AXI_WREADY), 32'h1);
    tick();
    S_AXI_WVALID = 1'b0;
    check("t3_w_captured", 32'(S_AXI_WREADY), 32'h0);
    tick();
    tick();
    check("t3_no_early_b", 32'(S_AXI_BVALID), 32'h0);
    check("t3_out_unchanged", gpio_o, 32'h00A5_00FF);
    S_AXI_AWADDR = 4'h0;
    S_AXI_AWVALID = 1'b1;
    check("t3_awready", 32'(S_AXI_AWREADY), 32'h1);
    tick();
    S_AXI_AWVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t3_bvalid_held", 32'(S_AXI_BVALID), 32'h1);
      check("t3_awready_low", 32'(S_AXI_AWREADY), 32'h0);
      check("t3_wready_low", 32'(S_AXI_WREADY), 32'h0);
      tick();
    end
    check("t3_bresp", 32'(S_AXI_BRESP), 32'h0);
    S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;
    check("t3_bvalid_clear", 32'(S_AXI_BVALID), 32'h0);
    check("t3_gpio_o", gpio_o, 32'h1234_5678);
    axi_write(4'h4, 32'h0, 4'hF);
    gpio_i = 32'h0000_0008;
    tick();
    tick();
    tick();
    axi_read(4'h8, 0, rd);
    check("t4_in", rd, 32'h0000_0008);
    axi_read(4'hC, 0, rd);
    check("t4_stat", rd, 32'h0000_0008);
    check("t4_irq_set", 32'(irq), 32'h1);
    axi_write(4'hC, 32'h0000_0008, 4'hF);
    check("t4_irq_clear", 32'(irq), 32'h0);
    axi_read(4'hC, 0, rd);
    check("t4_stat_clear", rd, 32'h0);
    gpio_i = 32'h0;
    for (int i = 0; i < 4; i++) tick();
    check("t5_no_irq_on_fall", 32'(irq), 32'h0);
    gpio_i = 32'h0000_0008;
    tick();
    tick();
    S_AXI_AWADDR = 4'hC;
    S_AXI_WDATA = 32'h0000_0008;
    S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID = 1'b1;
    check("t5_ready_both", 32'({S_AXI_AWREADY, S_AXI_WREADY}), 32'h3);
    tick();
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID = 1'b0;
    check("t5_bvalid", 32'(S_AXI_BVALID), 32'h1);
    S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;
    check("t5_irq_set_wins", 32'(irq), 32'h1);
    axi_read(4'hC, 0, rd);
    check("t5_stat", rd, 32'h0000_0008);
    axi_write(4'h4, 32'h0000_FF00, 4'hF);
    check("t6_gpio_oe", gpio_oe, 32'h0000_FF00);
    axi_read(4'h0, 2, rd);
    check("t6_rd_out", rd, 32'h1234_5678);
    axi_read(4'h4, 2, rd);
    check("t6_rd_dir", rd, 32'h0000_FF00);
    axi_read(4'h8, 2, rd);
    check("t6_rd_in", rd, 32'h0000_0008);
    axi_read(4'hC, 2, rd);
    check("t6_rd_stat", rd, 32'h0000_0008);
    axi_write(4'h8, 32'hFFFF_FFFF, 4'hF);
    axi_read(4'h8, 0, rd);
    check("t6_in_ro", rd, 32'h0000_0008);
    check("t6_out_kept", gpio_o, 32'h1234_5678);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
